// File: rtl/omsp_hkdf_key_loader.sv
// HKDF derived-key collector: packs 16-bit words into a key buffer and commits it
// to the SPM key store over a req/ack handshake, zeroising the buffer afterwards.
module omsp_hkdf_key_loader #(
    parameter int KEY_WORDS = 8,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write_key,
    input  logic [15:0]             key_word,
    input  logic                    commit,
    input  logic                    key_wr_ack,
    output logic                    key_wr_en,
    output logic [16*KEY_WORDS-1:0] key_out,
    output logic [CNT_W-1:0]        word_count,
    output logic                    full,
    output logic                    done,
    output logic                    error
);

    localparam int KW = 16 * KEY_WORDS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_FULL    = 3'd2,
        S_COMMIT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     buffer, buffer_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              error_nxt;
    logic              key_wr_en_nxt;
    logic              full_nxt;
    logic              done_nxt;

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            buffer    <= '0;
            count     <= '0;
            error     <= 1'b0;
            key_wr_en <= 1'b0;
            full      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            buffer    <= buffer_nxt;
            count     <= count_nxt;
            error     <= error_nxt;
            key_wr_en <= key_wr_en_nxt;
            full      <= full_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (commit)
                        state_nxt = S_IDLE;
                    else if (write_key)
                        state_nxt = (KEY_WORDS == 1) ? S_FULL : S_COLLECT;
                    else
                        state_nxt = S_IDLE;
                end
                S_COLLECT: begin
                    if (commit)
                        state_nxt = S_IDLE;
                    else if (write_key && count == LAST_IDX)
                        state_nxt = S_FULL;
                end
                S_FULL: begin
                    // Overflow takes precedence over a coincident commit.
                    if (write_key)
                        state_nxt = S_IDLE;
                    else if (commit)
                        state_nxt = S_COMMIT;
                end
                S_COMMIT: begin
                    if (key_wr_ack)
                        state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        buffer_nxt = buffer;
        count_nxt  = count;
        error_nxt  = error;
        if (clear) begin
            buffer_nxt = '0;
            count_nxt  = '0;
            error_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_COLLECT, S_DONE: begin
                    if (commit) begin
                        error_nxt  = 1'b1;
                        buffer_nxt = '0;
                        count_nxt  = '0;
                    end else if (write_key) begin
                        buffer_nxt = KW'({buffer, key_word});
                        count_nxt  = count + CNT_W'(1);
                    end
                end
                S_FULL: begin
                    if (write_key) begin
                        error_nxt  = 1'b1;
                        buffer_nxt = '0;
                        count_nxt  = '0;
                    end
                end
                S_COMMIT: begin
                    if (key_wr_ack) begin
                        buffer_nxt = '0;
                        count_nxt  = '0;
                    end
                end
                default: begin
                    buffer_nxt = '0;
                    count_nxt  = '0;
                end
            endcase
        end
        key_wr_en_nxt = (state_nxt == S_COMMIT);
        full_nxt      = (state_nxt == S_FULL);
        done_nxt      = (state_nxt == S_DONE);
    end

    assign word_count = count;
    // Key material is only visible on the bus while a write is requested.
    assign key_out    = buffer & {KW{key_wr_en}};

endmodule

// File: tb/tb_omsp_hkdf_key_loader.sv
// Randomized scoreboard bench for omsp_hkdf_key_loader against a word-queue model.
module tb_omsp_hkdf_key_loader;

    localparam int KWORDS = 8;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          write_key = 1'b0;
    logic [15:0]   key_word = '0;
    logic          commit = 1'b0;
    logic          key_wr_ack = 1'b0;
    logic          key_wr_en;
    logic [127:0]  key_out;
    logic [CW-1:0] word_count;
    logic          full;
    logic          done;
    logic          error;

    omsp_hkdf_key_loader #(.KEY_WORDS(KWORDS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .write_key(write_key),
        .key_word(key_word), .commit(commit), .key_wr_ack(key_wr_ack),
        .key_wr_en(key_wr_en), .key_out(key_out), .word_count(word_count),
        .full(full), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           len;
        bit           dn;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] words[$];
    bit          merr = 1'b0;
    bit          ack_tie = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_key();
        logic [127:0] k = '0;
        foreach (words[i]) k = k | ({112'd0, words[i]} << (16 * (KWORDS - 1 - i)));
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        write_key = 1'b0;
        commit    = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_count"}, 128'(word_count), 128'(words.size()));
        chk({tag, "_full"},  128'(full),       128'(words.size() == KWORDS));
        chk({tag, "_error"}, 128'(error),      128'(merr));
        chk({tag, "_wr_en"}, 128'(key_wr_en),  128'(0));
    endtask

    task automatic do_write(input logic [15:0] w);
        key_word  = w;
        write_key = 1'b1;
        tick();
        if (words.size() == KWORDS) begin
            merr = 1'b1;
            words.delete();
        end else begin
            words.push_back(w);
        end
    endtask

    task automatic do_clear(input bit with_strobe);
        clear = 1'b1;
        if (with_strobe) begin
            write_key = 1'b1;
            key_word  = 16'(($urandom));
        end
        tick();
        words.delete();
        merr = 1'b0;
        check_regs("clear");
    endtask

    // Full commit sequence; clr2 aborts with clear+ack in the second request cycle.
    task automatic do_commit(input int dly, input bit clr2);
        exp_t e;
        int   d;
        commit = 1'b1;
        tick();
        if (words.size() != KWORDS) begin
            merr = 1'b1;
            words.delete();
            check_regs("early_commit");
            tick();
            chk("early_commit_no_wr", 128'(key_wr_en), 128'(0));
            return;
        end
        d     = clr2 ? 1 : dly;
        e.key = model_key();
        e.len = d + 1;
        e.dn  = !clr2;
        exp_q.push_back(e);
        for (int i = 0; i < d; i++) begin
            write_key = 1'($urandom);
            key_word  = 16'($urandom);
            commit    = 1'($urandom);
            tick();
        end
        key_wr_ack = 1'b1;
        if (clr2) clear = 1'b1;
        tick();
        key_wr_ack = ack_tie;
        words.delete();
        if (clr2) merr = 1'b0;
        tick();
        check_regs(clr2 ? "commit_clr" : "commit");
    endtask

    // Monitor: pops an expected key whenever a write request starts.
    initial begin
        exp_t cur;
        bit   en_d = 1'b0;
        int   run = 0;
        cur.key = '0; cur.len = 0; cur.dn = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_d = 1'b0;
            end else begin
                if (key_wr_en && !en_d) begin
                    run = 1;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_wr key_out=%0h expected no request", key_out);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("wr_key", key_out, cur.key);
                    end
                end else if (key_wr_en) begin
                    run++;
                    chk("wr_key_stable", key_out, cur.key);
                end
                if (!key_wr_en && en_d) begin
                    chk("wr_len", 128'(run), 128'(cur.len));
                    chk("done_after_wr", 128'(done), 128'(cur.dn));
                end else if (done) begin
                    checks++; failures++;
                    $display("FAIL stray_done done=1 expected 0");
                end
                if (!key_wr_en) chk("key_out_zero", key_out, 128'(0));
                en_d = key_wr_en;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sel, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_out", key_out, 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        reset = 1'b0;
        check_regs("reset");

        // Known-answer key, ack after 3 cycles.
        for (int i = 1; i <= 8; i++) do_write(16'(i));
        chk("kat_model", model_key(), 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        do_commit(3, 1'b0);

        // Overflow, then a commit that must not write.
        for (int i = 0; i < 8; i++) do_write(16'($urandom));
        do_write(16'hFFFF);
        check_regs("overflow");
        do_commit(0, 1'b0);

        // Early commit after 5 words (error stays sticky).
        for (int i = 0; i < 5; i++) do_write(16'($urandom));
        do_commit(0, 1'b0);

        // Abort during the handshake.
        for (int i = 0; i < 8; i++) do_write(16'($urandom));
        do_commit(0, 1'b1);

        // Asynchronous reset mid-collection.
        for (int i = 0; i < 3; i++) do_write(16'($urandom));
        chk("pre_rst_count", 128'(word_count), 128'(3));
        #3 reset = 1'b1;
        #1;
        chk("arst_count", 128'(word_count), 128'(0));
        chk("arst_full",  128'(full),       128'(0));
        chk("arst_error", 128'(error),      128'(0));
        chk("arst_done",  128'(done),       128'(0));
        chk("arst_wr_en", 128'(key_wr_en),  128'(0));
        chk("arst_key",   key_out,          128'(0));
        words.delete();
        merr = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) do_write(16'($urandom));
        do_commit(1, 1'b0);

        // Ack tied high: single-cycle handshake.
        ack_tie = 1'b1; key_wr_ack = 1'b1;
        for (int i = 0; i < 8; i++) do_write(16'($urandom));
        do_commit(0, 1'b0);
        ack_tie = 1'b0; key_wr_ack = 1'b0;

        // Randomized scenario mix.
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin
                    for (int i = 0; i < 8; i++) do_write(16'($urandom));
                    do_commit($urandom_range(0, 4), 1'b0);
                end
                1: begin
                    n = $urandom_range(0, 7);
                    for (int i = 0; i < n; i++) do_write(16'($urandom));
                    do_commit(0, 1'b0);
                end
                2: begin
                    for (int i = 0; i < 9; i++) do_write(16'($urandom));
                    check_regs("rnd_overflow");
                end
                3: begin
                    for (int i = 0; i < 8; i++) do_write(16'($urandom));
                    do_commit(0, 1'b1);
                end
                default: begin
                    n = $urandom_range(0, 8);
                    for (int i = 0; i < n; i++) do_write(16'($urandom));
                    check_regs("rnd_collect");
                    do_clear(1'($urandom));
                end
            endcase
        end

        tick(); tick();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/omsp_hkdf_key_loader.md
# omsp_hkdf_key_loader

Collects the derived-key words produced by the HMAC control FSM during an HKDF operation (one 16-bit word per `write_key` pulse) into a 128-bit key buffer. It then commits the buffered key to the SPM key store through a request/acknowledge handshake. It sits directly downstream of the HMAC control block's key-output path and upstream of the SPM key register file. The buffer is zeroised after every commit, clear or error so derived key material never lingers.

## Interface
- `KEY_WORDS`, default 8: number of 16-bit words per key; key width = 16·KEY_WORDS.
- `CNT_W`, default 4: width of the word counter; must satisfy 2^CNT_W > KEY_WORDS.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort/zeroise; driven by the HMAC control `hmac_reset`.
- `write_key`  in  1  one-cycle strobe; `key_word` is valid in the same cycle.
- `key_word`  in  16  derived-key word, big-endian order (first word = most-significant).
- `commit`  in  1  one-cycle strobe requesting a store of the completed key.
- `key_wr_ack`  in  1  SPM key store has latched `key_out`.
- `key_wr_en`  out  1  write request to the SPM key store.
- `key_out`  out  16·KEY_WORDS  key data; forced to 0 whenever `key_wr_en`=0.
- `word_count`  out  CNT_W  number of words currently buffered.
- `full`  out  1  buffer holds KEY_WORDS words.
- `done`  out  1  one-cycle pulse after a successful commit.
- `error`  out  1  sticky: overflow, or commit before full.

## Operation
- States: IDLE, COLLECT, FULL, COMMIT, DONE.
- Shift on accept: buffer ← {buffer[16·KEY_WORDS-17:0], key_word}; word_count++.
- IDLE: `write_key` accepts the word; next state is COLLECT, or FULL if KEY_WORDS=1.
- COLLECT: `write_key` accepts the word. When the accepted word makes word_count = KEY_WORDS, next state is FULL.
- FULL: `full`=1.
  - `write_key` does not shift; it sets `error`, zeroises the buffer and count, and returns to IDLE.
  - `commit` moves to COMMIT.
- `commit` in IDLE or COLLECT: sets `error`, zeroises the buffer, returns to IDLE.
- COMMIT: `key_wr_en`=1 and `key_out`=buffer, held stable until `key_wr_ack`=1 is sampled.
  - On ack: zeroise buffer and count, go to DONE.
  - `write_key` or `commit` in COMMIT are ignored (no error).
- DONE: `done`=1 for one cycle, then IDLE.
- `clear` has top priority in every state:
  - next cycle is IDLE with buffer, count and `error` = 0;
  - any simultaneous `write_key`, `commit` or `key_wr_ack` is discarded;
  - a clear during COMMIT drops `key_wr_en` the next cycle and writes no key.
- `error` is cleared only by `clear` or `reset`; it does not block new collection after returning to IDLE.

## Timing
- Reset values: state IDLE, buffer 0, `word_count` 0, `full` 0, `key_wr_en` 0, `key_out` 0, `done` 0, `error` 0.
- `write_key` is sampled every cycle. Back-to-back strobes are each accepted, so 8 words take 8 cycles minimum. The HMAC control spaces them at least 2 cycles apart.
- `word_count` and `full` update the cycle after the accepting edge.
- `key_wr_en` rises 1 cycle after `commit`.
- `key_wr_ack` may arrive in the first `key_wr_en` cycle (minimum 1-cycle handshake) or any later cycle.
- `key_wr_en` and `key_out` drop the cycle after ack; `done` is high in that same cycle.
- Counter arithmetic is unsigned CNT_W bits and never wraps: the overflow rule fires before word_count can exceed KEY_WORDS.
- All outputs are registered except `key_out`, which is the buffer ANDed with `key_wr_en`.

## Test plan
- 8 strobes with words 0x0001..0x0008, then `commit`, ack after 3 cycles:
  - `key_out` = 0x0001000200030004000500060007_0008 while `key_wr_en` is high;
  - one `done` pulse;
  - `key_out` = 0 afterwards; `error` = 0.
- 8 words, then a 9th `write_key` with 0xFFFF:
  - `error` = 1, `word_count` = 0, state IDLE;
  - a following `commit` leaves `key_wr_en` at 0.
- 5 words, then `commit`: `error` = 1, `word_count` = 0, no `key_wr_en`.
- 8 words, `commit`, then `clear` in the second `key_wr_en` cycle with ack high in the same cycle:
  - `key_wr_en` = 0 next cycle;
  - no `done`; `error` = 0; `key_out` = 0.
- `reset` asserted asynchronously mid-collection (word_count = 3): all outputs 0 immediately.
  - After release, 8 fresh words commit correctly.
- Ack tied high (1-cycle handshake), back-to-back `write_key` every cycle:
  - `key_wr_en` is high for exactly 1 cycle;
  - `done` follows in the next cycle.
